// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master side requests conversions; the slave side is the converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_WIDTH = 20,
  parameter int DIGITS    = 6
);
  logic                  start;
  logic [BIN_WIDTH-1:0]  value;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start, value,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, value,
    output busy, done, bcd, overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 binary to packed BCD converter, one iteration per clock.
// Holds the last result for the display and flags values that need a 7th digit.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 20,
  parameter int DIGITS    = 6
) (
  input  logic                clock,
  input  logic                reset_n,
  bin_to_bcd_seq_if.slave     bus
);

  localparam int BCD_W = (DIGITS + 1) * 4;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_WIDTH - 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  // The guard digit must be able to hold the top digit of the largest input.
  if (pow10(DIGITS + 1) <= ((64'd1 << BIN_WIDTH) - 64'd1)) begin : g_width_check
    $error("bin_to_bcd_seq: DIGITS+1 digits cannot represent 2**BIN_WIDTH-1");
  end

  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] x);
    logic [BCD_W-1:0] r;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (x[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = x[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = x[4*i +: 4];
      end
    end
    return r;
  endfunction

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BCD_W-1:0]         bcd_sh_q, bcd_sh_d;
  logic [BIN_WIDTH-1:0]     bin_q, bin_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [4*DIGITS-1:0]      bcd_q, bcd_d;
  logic                     ovf_q, ovf_d;

  logic [BCD_W-1:0]           adj_s;
  logic [BCD_W+BIN_WIDTH-1:0] shifted_s;

  // Next-state and next-output computation for the conversion FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcd_sh_d = bcd_sh_q;
    bin_d    = bin_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;

    adj_s     = add3_all(bcd_sh_q);
    shifted_s = {adj_s[BCD_W-2:0], bin_q, 1'b0};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d    = bus.value;
          bcd_sh_d = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end else begin
          busy_d = 1'b0;
        end
      end
      SHIFT: begin
        bcd_sh_d = shifted_s[BIN_WIDTH +: BCD_W];
        bin_d    = shifted_s[BIN_WIDTH-1:0];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = bcd_sh_d[4*DIGITS-1:0];
          ovf_d   = (bcd_sh_d[BCD_W-1 -: 4] != 4'd0);
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bcd_sh_q <= '0;
      bin_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bcd_sh_q <= bcd_sh_d;
      bin_q    <= bin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;

endmodule
